// File: rtl/sw_seq_feeder_if.sv
// Bundle of host-load, start/status, PE-controller serve and writeback signals
// for sw_seq_feeder.
//   master : host + PE array controller side (drives i_*, observes o_*)
//   slave  : the feeder itself
// Optional macro SW_FEEDER_STATUS_EN adds o_pass_cnt / o_fifo_level status outputs.
interface sw_seq_feeder_if #(
    parameter int unsigned V_E_F_BIT = 16,
    parameter int unsigned T_DEPTH   = 256
);
    localparam int unsigned TAW = $clog2(T_DEPTH);

    // Host load path
    logic                 i_load_valid;
    logic                 i_load_sel;
    logic [1:0]           i_load_sym;
    logic                 i_load_last;
    // Control / status
    logic                 i_start;
    logic                 o_busy;
    logic                 o_err;
    // Serve path to the controller
    logic                 o_data_valid;
    logic                 i_update_s_w;
    logic [1:0]           o_s;
    logic                 o_s_last;
    logic                 i_update_t_w;
    logic [1:0]           o_t;
    logic [V_E_F_BIT-1:0] o_v;
    logic [V_E_F_BIT-1:0] o_f;
    logic                 o_t_last;
    // Column writeback from the controller
    logic                 i_t_valid;
    logic [1:0]           i_t;
    logic [V_E_F_BIT-1:0] i_v;
    logic [V_E_F_BIT-1:0] i_f;
`ifdef SW_FEEDER_STATUS_EN
    logic [15:0]          o_pass_cnt;
    logic [TAW:0]         o_fifo_level;
`endif

    modport master (
`ifdef SW_FEEDER_STATUS_EN
        input  o_pass_cnt, o_fifo_level,
`endif
        output i_load_valid, i_load_sel, i_load_sym, i_load_last, i_start,
        output i_update_s_w, i_update_t_w, i_t_valid, i_t, i_v, i_f,
        input  o_busy, o_err, o_data_valid, o_s, o_s_last, o_t, o_v, o_f, o_t_last
    );

    modport slave (
`ifdef SW_FEEDER_STATUS_EN
        output o_pass_cnt, o_fifo_level,
`endif
        input  i_load_valid, i_load_sel, i_load_sym, i_load_last, i_start,
        input  i_update_s_w, i_update_t_w, i_t_valid, i_t, i_v, i_f,
        output o_busy, o_err, o_data_valid, o_s, o_s_last, o_t, o_v, o_f, o_t_last
    );
endinterface

// File: rtl/sw_seq_feeder.sv
// Sequence feeder for the Smith-Waterman PE array controller.
// Holds query S and database T (2-bit symbols). During RUN it serves S symbols
// and column words (t, v, f) on the controller's update strobes. Pass 0 serves
// T from the T buffer with v = f = 0; each returned column is written into a
// circular column FIFO that is replayed as the column stream of the next pass.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sw_seq_feeder_if.slave (load, start/busy/err, serve, writeback)
// Optional macro SW_FEEDER_STATUS_EN adds registered status outputs
// bus.o_pass_cnt (current pass) and bus.o_fifo_level (column FIFO occupancy).
module sw_seq_feeder #(
    parameter int unsigned V_E_F_BIT = 16,
    parameter int unsigned S_DEPTH   = 256,
    parameter int unsigned T_DEPTH   = 256
) (
    input logic           clk,
    input logic           rst_n,
    sw_seq_feeder_if.slave bus
);
    localparam int unsigned SAW = $clog2(S_DEPTH);
    localparam int unsigned TAW = $clog2(T_DEPTH);
    localparam int unsigned WW  = 2 + 2 * V_E_F_BIT;

    localparam logic [SAW:0] SOne     = (SAW + 1)'(1);
    localparam logic [TAW:0] TOne     = (TAW + 1)'(1);
    localparam logic [TAW:0] FifoFull = (TAW + 1)'(T_DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q, state_d;

    logic [1:0]     s_mem    [S_DEPTH];
    logic [1:0]     t_mem    [T_DEPTH];
    logic [WW-1:0]  fifo_mem [T_DEPTH];

    logic [SAW-1:0] s_wptr_q, s_idx_q;
    logic [SAW:0]   s_len_q;
    logic [TAW-1:0] t_wptr_q, t_idx_q;
    logic [TAW:0]   t_len_q;
    logic [TAW-1:0] head_q, tail_q;
    logic [TAW:0]   level_q;
    logic [15:0]    pass_q;
    logic           s_exh_q;
    logic           busy_q;
    logic           err_q;

    logic idle, run, pass0;
    logic load_s, load_t;
    logic start_ok, start_bad;
    logic data_valid, s_last, t_last;
    logic s_adv, t_adv, pop;
    logic push_req, push, overflow, finish;
    logic [WW-1:0] head_word;

    assign idle  = (state_q == StIdle);
    assign run   = (state_q == StRun);
    assign pass0 = (pass_q == 16'd0);

    assign load_s = idle && bus.i_load_valid && !bus.i_load_sel;
    assign load_t = idle && bus.i_load_valid &&  bus.i_load_sel;

    assign start_ok  = idle && bus.i_start && (s_len_q != '0) && (t_len_q != '0);
    assign start_bad = idle && bus.i_start && ((s_len_q == '0) || (t_len_q == '0));

    // Pass 0 streams from the T buffer, later passes only while the FIFO holds a word.
    assign data_valid = run && (pass0 || (level_q != '0));

    assign s_last = run && !s_exh_q && ({1'b0, s_idx_q} == (s_len_q - SOne));
    assign t_last = data_valid && ({1'b0, t_idx_q} == (t_len_q - TOne));

    // Once S is exhausted further S strobes are meaningless: S never rewinds.
    assign s_adv = data_valid && bus.i_update_s_w && !s_exh_q;
    assign t_adv = data_valid && bus.i_update_t_w;
    assign pop   = t_adv && !pass0;

    // Columns returned after S is exhausted are never replayed, so drop them.
    assign push_req = run && !s_exh_q && bus.i_t_valid;
    assign overflow = push_req && (level_q == FifoFull) && !pop;
    assign push     = push_req && !overflow;

    assign finish = t_adv && t_last && (s_exh_q || (s_adv && s_last));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_ok) state_d = StRun;
            StRun:   if (finish) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            s_wptr_q <= '0;
            s_idx_q  <= '0;
            s_len_q  <= '0;
            t_wptr_q <= '0;
            t_idx_q  <= '0;
            t_len_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            level_q  <= '0;
            pass_q   <= '0;
            s_exh_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != StIdle);
            if (start_bad || overflow) err_q <= 1'b1;

            if (load_s) begin
                if (bus.i_load_last) begin
                    s_len_q  <= {1'b0, s_wptr_q} + SOne;
                    s_wptr_q <= '0;
                end else begin
                    s_wptr_q <= s_wptr_q + SAW'(1);
                end
            end
            if (load_t) begin
                if (bus.i_load_last) begin
                    t_len_q  <= {1'b0, t_wptr_q} + TOne;
                    t_wptr_q <= '0;
                end else begin
                    t_wptr_q <= t_wptr_q + TAW'(1);
                end
            end

            if (start_ok) begin
                s_idx_q <= '0;
                t_idx_q <= '0;
                s_exh_q <= 1'b0;
                pass_q  <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                level_q <= '0;
            end else begin
                if (s_adv) begin
                    if (s_last) s_exh_q <= 1'b1;
                    else        s_idx_q <= s_idx_q + SAW'(1);
                end
                if (t_adv) begin
                    if (t_last) begin
                        t_idx_q <= '0;
                        pass_q  <= pass_q + 16'd1;
                    end else begin
                        t_idx_q <= t_idx_q + TAW'(1);
                    end
                end
                if (pop)  head_q <= head_q + TAW'(1);
                if (push) tail_q <= tail_q + TAW'(1);
                if (push && !pop)      level_q <= level_q + TOne;
                else if (pop && !push) level_q <= level_q - TOne;
            end
        end
    end

    // Storage arrays carry no reset; their contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (load_s) s_mem[s_wptr_q] <= bus.i_load_sym;
        if (load_t) t_mem[t_wptr_q] <= bus.i_load_sym;
        if (push)   fifo_mem[tail_q] <= {bus.i_t, bus.i_v, bus.i_f};
    end

    assign head_word = fifo_mem[head_q];

    assign bus.o_busy       = busy_q;
    assign bus.o_err        = err_q;
    assign bus.o_data_valid = data_valid;
    assign bus.o_s          = run ? s_mem[s_idx_q] : 2'b00;
    assign bus.o_s_last     = s_last;
    assign bus.o_t_last     = t_last;

    always_comb begin
        bus.o_t = 2'b00;
        bus.o_v = '0;
        bus.o_f = '0;
        if (data_valid) begin
            if (pass0) begin
                bus.o_t = t_mem[t_idx_q];
            end else begin
                bus.o_t = head_word[WW-1 -: 2];
                bus.o_v = head_word[2*V_E_F_BIT-1 -: V_E_F_BIT];
                bus.o_f = head_word[V_E_F_BIT-1:0];
            end
        end
    end

`ifdef SW_FEEDER_STATUS_EN
    assign bus.o_pass_cnt   = pass_q;
    assign bus.o_fifo_level = level_q;
`endif

endmodule

// File: tb/tb_sw_seq_feeder.sv
// Directed bench for sw_seq_feeder with a small column FIFO (T_DEPTH = 4).
// Expected column words are queued when loaded or written back and popped as
// the DUT serves them.
module tb_sw_seq_feeder;
    localparam int unsigned VW = 16;
    localparam int unsigned SD = 4;
    localparam int unsigned TD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sw_seq_feeder_if #(.V_E_F_BIT(VW), .T_DEPTH(TD)) bus ();

    sw_seq_feeder #(.V_E_F_BIT(VW), .S_DEPTH(SD), .T_DEPTH(TD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0]    t;
        logic [VW-1:0] v;
        logic [VW-1:0] f;
    } word_t;

    word_t exp_q[$];
    int total = 0;
    int bad = 0;
    int emit_cnt = 0;
    int tlen = 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the word currently served against the scoreboard head.
    task automatic chk_word(input string tag);
        word_t e;
        chk({tag, "_have"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 32'(bus.o_data_valid), 32'd1);
            chk({tag, "_t"}, 32'(bus.o_t), 32'(e.t));
            chk({tag, "_v"}, 32'(bus.o_v), 32'(e.v));
            chk({tag, "_f"}, 32'(bus.o_f), 32'(e.f));
            chk({tag, "_tlast"}, 32'(bus.o_t_last), 32'((emit_cnt % tlen) == (tlen - 1)));
            emit_cnt++;
        end
    endtask

    task automatic load(input logic sel, input logic [1:0] syms[$]);
        foreach (syms[i]) begin
            bus.i_load_valid = 1'b1;
            bus.i_load_sel   = sel;
            bus.i_load_sym   = syms[i];
            bus.i_load_last  = (i == syms.size() - 1);
            tick();
        end
        bus.i_load_valid = 1'b0;
        bus.i_load_last  = 1'b0;
        if (sel) tlen = syms.size();
    endtask

    // Queue pass-0 words (T symbols, v = f = 0) and pulse start.
    task automatic start_run(input logic [1:0] tq[$]);
        word_t w;
        foreach (tq[i]) begin
            w.t = tq[i];
            w.v = '0;
            w.f = '0;
            exp_q.push_back(w);
        end
        emit_cnt = 0;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic wb(input logic [1:0] t, input logic [VW-1:0] v, input logic [VW-1:0] f,
                      input bit keep);
        word_t w;
        bus.i_t_valid = 1'b1;
        bus.i_t = t;
        bus.i_v = v;
        bus.i_f = f;
        w.t = t;
        w.v = v;
        w.f = f;
        if (keep) exp_q.push_back(w);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] sq[$];
        logic [1:0] tq[$];
        logic [1:0]    wbt[3];
        logic [VW-1:0] wbv[3];
        logic [VW-1:0] wbf[3];
        wbt = '{2'd3, 2'd2, 2'd1};
        wbv = '{16'd5, 16'd7, 16'd4};
        wbf = '{16'd1, 16'd0, 16'd2};

        bus.i_load_valid = 1'b0; bus.i_load_sel = 1'b0; bus.i_load_sym = 2'd0;
        bus.i_load_last = 1'b0; bus.i_start = 1'b0; bus.i_update_s_w = 1'b0;
        bus.i_update_t_w = 1'b0; bus.i_t_valid = 1'b0; bus.i_t = 2'd0;
        bus.i_v = '0; bus.i_f = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_valid", 32'(bus.o_data_valid), 0);
        chk("rst_err", 32'(bus.o_err), 0);
        chk("rst_s", 32'(bus.o_s), 0);
        chk("rst_tlast", 32'(bus.o_t_last), 0);
        rst_n = 1'b1;
        tick();

        // Pass 0 with both strobes held high; ends in DONE after the 3rd word
        sq = {2'd0, 2'd1}; load(1'b0, sq);
        tq = {2'd2, 2'd3, 2'd1}; load(1'b1, tq);
        start_run(tq);
        chk("t1_busy", 32'(bus.o_busy), 1);
        bus.i_update_s_w = 1'b1; bus.i_update_t_w = 1'b1;
        chk_word("t1_w0"); chk("t1_s0", 32'(bus.o_s), 0); chk("t1_slast0", 32'(bus.o_s_last), 0);
        tick();
        chk_word("t1_w1"); chk("t1_s1", 32'(bus.o_s), 1); chk("t1_slast1", 32'(bus.o_s_last), 1);
        tick();
        chk_word("t1_w2"); chk("t1_slast_exh", 32'(bus.o_s_last), 0);
        tick();
        chk("t1_done_busy", 32'(bus.o_busy), 1);
        chk("t1_done_valid", 32'(bus.o_data_valid), 0);
        tick();
        chk("t1_idle_busy", 32'(bus.o_busy), 0);
        chk("t1_idle_valid", 32'(bus.o_data_valid), 0);
        bus.i_update_s_w = 1'b0; bus.i_update_t_w = 1'b0;
        chk("t1_sb_drained", 32'(exp_q.size()), 0);

        // Writeback during pass 0, replay in pass 1, then an empty FIFO in pass 2
        load(1'b0, sq);
        load(1'b1, tq);
        start_run(tq);
        bus.i_update_t_w = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_word("t2_p0");
            wb(wbt[i], wbv[i], wbf[i], 1'b1);
            tick();
        end
        bus.i_t_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_word("t2_p1");
            chk("t2_p1_s", 32'(bus.o_s), 0);
            tick();
        end
        bus.i_update_s_w = 1'b1;
        chk("t3_empty_valid", 32'(bus.o_data_valid), 0);
        tick();
        chk("t3_empty_valid2", 32'(bus.o_data_valid), 0);
        chk("t3_s_held", 32'(bus.o_s), 0);
        chk("t3_slast_held", 32'(bus.o_s_last), 0);
        bus.i_update_s_w = 1'b0; bus.i_update_t_w = 1'b0;
        wb(2'd0, 16'd9, 16'd3, 1'b1);
        tick();
        bus.i_t_valid = 1'b0;
        chk_word("t3_p2");
        rst_n = 1'b0;
        #1;
        chk("t3_rst_busy", 32'(bus.o_busy), 0);
        chk("t3_rst_valid", 32'(bus.o_data_valid), 0);
        chk("t3_rst_s", 32'(bus.o_s), 0);
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.delete();

        // s_len=1, t_len=2: s_last and t_last consumed together
        sq = {2'd3}; load(1'b0, sq);
        tq = {2'd1, 2'd2}; load(1'b1, tq);
        start_run(tq);
        chk("t4_s", 32'(bus.o_s), 3);
        chk("t4_slast", 32'(bus.o_s_last), 1);
        bus.i_update_t_w = 1'b1;
        chk_word("t4_w0");
        tick();
        bus.i_update_s_w = 1'b1;
        chk_word("t4_w1");
        tick();
        chk("t4_done_busy", 32'(bus.o_busy), 1);
        chk("t4_done_valid", 32'(bus.o_data_valid), 0);
        bus.i_update_s_w = 1'b0; bus.i_update_t_w = 1'b0;
        wb(2'd1, 16'd1, 16'd1, 1'b0);
        tick();
        bus.i_t_valid = 1'b0;
        chk("t4_idle_busy", 32'(bus.o_busy), 0);
        chk("t4_err", 32'(bus.o_err), 0);
        chk("t4_sb_drained", 32'(exp_q.size()), 0);

        // FIFO overflow: 5 pushes into a 4-deep FIFO with no pops
        sq = {2'd0, 2'd1}; load(1'b0, sq);
        tq = {2'd2, 2'd3, 2'd1}; load(1'b1, tq);
        start_run(tq);
        for (int i = 0; i < 4; i++) begin
            wb(2'(i), 16'(10 + i), 16'(20 + i), 1'b1);
            tick();
        end
        chk("t5_err_before", 32'(bus.o_err), 0);
        wb(2'd3, 16'hdead, 16'hbeef, 1'b0);
        tick();
        bus.i_t_valid = 1'b0;
        chk("t5_err_after", 32'(bus.o_err), 1);
        bus.i_update_t_w = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk_word("t5_w");
            tick();
        end
        chk("t5_dropped_valid", 32'(bus.o_data_valid), 0);
        bus.i_update_t_w = 1'b0;
        chk("t5_err_sticky", 32'(bus.o_err), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_err", 32'(bus.o_err), 0);
        chk("t5_rst_busy", 32'(bus.o_busy), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Zero-length start after reset
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        chk("t6_err", 32'(bus.o_err), 1);
        chk("t6_busy", 32'(bus.o_busy), 0);
        chk("t6_valid", 32'(bus.o_data_valid), 0);
        tick();
        chk("t6_busy2", 32'(bus.o_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
